// File: rtl/concatenador_numeros_pkg.sv
// Shared definitions for the decimal digit concatenator.
//   - FSM state encodings (IDLE, ACUM)
//   - ASCII_ZERO: ASCII code of '0'
//   - DEFAULT_WIDTH: default accumulator / result width
package concat_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam logic [7:0]  ASCII_ZERO    = 8'h30;

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_ACUM = 1'b1;

endpackage : concat_pkg

// File: rtl/concatenador_numeros_decodificador.sv
// Combinational digit decoder.
//   dato         in  8  raw value 0..9, or ASCII '0'..'9' when ACCEPT_ASCII=1
//   digit        out 4  decoded decimal digit (meaningful only when valid)
//   valid        out 1  dato is an accepted digit encoding
module decodificador_digito
    import concat_pkg::*;
#(
    parameter bit ACCEPT_ASCII = 1'b1
) (
    input  logic [7:0] dato,
    output logic [3:0] digit,
    output logic       valid
);

    logic [7:0] ascii_off;

    assign ascii_off = dato - ASCII_ZERO;

    always_comb begin
        digit = 4'd0;
        valid = 1'b0;
        if (dato < 8'd10) begin
            digit = dato[3:0];
            valid = 1'b1;
        end else if (ACCEPT_ASCII && (dato >= ASCII_ZERO) && (dato <= 8'h39)) begin
            digit = ascii_off[3:0];
            valid = 1'b1;
        end
    end

endmodule : decodificador_digito

// File: rtl/concatenador_numeros.sv
// Builds a binary integer from a stream of decimal digits, MSD first.
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-high reset
//   dato        in   8      digit to append (raw 0..9 or ASCII)
//   num_ready   in   1      digit strobe, rising edge appends dato
//   fin         in   1      end-of-number strobe, rising edge commits
//   resultado   out  WIDTH  last committed number
//   listo       out  1      one-cycle pulse after a commit
//   desborde    out  1      overflow flag of the last committed number
//   error_dato  out  1      one-cycle pulse on an invalid digit strobe
module concatenador_numeros
    import concat_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter bit          ACCEPT_ASCII = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       dato,
    input  logic             num_ready,
    input  logic             fin,
    output logic [WIDTH-1:0] resultado,
    output logic             listo,
    output logic             desborde,
    output logic             error_dato
);

    localparam int unsigned PW = WIDTH + 4;

    logic             num_ready_q, fin_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             listo_q, listo_d;
    logic             desb_q, desb_d;
    logic             err_q, err_d;

    logic [3:0]       digit_c;
    logic             valid_c;
    logic             num_ev_c, fin_ev_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] acc_app_c;
    logic             ovf_app_c;

    decodificador_digito #(
        .ACCEPT_ASCII(ACCEPT_ASCII)
    ) u_dec (
        .dato  (dato),
        .digit (digit_c),
        .valid (valid_c)
    );

    assign num_ev_c = num_ready & ~num_ready_q;
    assign fin_ev_c = fin & ~fin_q;

    // Product-sum is wide enough to hold (2^WIDTH-1)*10+9 without wrapping.
    assign prod_c = PW'(acc_q) * PW'(10) + PW'(digit_c);

    // Next-state: append is resolved first so a same-edge commit sees the new digit.
    always_comb begin
        acc_app_c = acc_q;
        ovf_app_c = ovf_q;
        state_d   = state_q;
        res_d     = res_q;
        desb_d    = desb_q;
        listo_d   = 1'b0;
        err_d     = num_ev_c & ~valid_c;

        if (num_ev_c && valid_c) begin
            if (|prod_c[PW-1:WIDTH]) begin
                acc_app_c = '1;
                ovf_app_c = 1'b1;
            end else begin
                acc_app_c = prod_c[WIDTH-1:0];
            end
            state_d = ST_ACUM;
        end

        acc_d = acc_app_c;
        ovf_d = ovf_app_c;

        if (fin_ev_c) begin
            res_d   = acc_app_c;
            desb_d  = ovf_app_c;
            listo_d = 1'b1;
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_ready_q <= 1'b0;
            fin_q       <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ST_IDLE;
            res_q       <= '0;
            listo_q     <= 1'b0;
            desb_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            num_ready_q <= num_ready;
            fin_q       <= fin;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            res_q       <= res_d;
            listo_q     <= listo_d;
            desb_q      <= desb_d;
            err_q       <= err_d;
        end
    end

    assign resultado  = res_q;
    assign listo      = listo_q;
    assign desborde   = desb_q;
    assign error_dato = err_q;

endmodule : concatenador_numeros

// File: tb/tb_concatenador_numeros.sv
// Self-checking bench for concatenador_numeros: table of digit strings
// followed by hand-written multi-cycle corner cases.
module tb_concatenador_numeros;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dato;
    logic        num_ready;
    logic        fin;
    logic [31:0] resultado;
    logic        listo;
    logic        desborde;
    logic        error_dato;

    int checks = 0;
    int fails  = 0;

    concatenador_numeros #(
        .WIDTH(32),
        .ACCEPT_ASCII(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dato       (dato),
        .num_ready  (num_ready),
        .fin        (fin),
        .resultado  (resultado),
        .listo      (listo),
        .desborde   (desborde),
        .error_dato (error_dato)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       digs;
        bit          ascii;
        logic [31:0] exp_res;
        bit          exp_ovf;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One-cycle num_ready pulse, driven on falling edges.
    task automatic pulse_digit(input logic [7:0] d);
        @(negedge clk);
        dato      = d;
        num_ready = 1'b1;
        @(negedge clk);
        num_ready = 1'b0;
    endtask

    // fin pulse; on return the commit edge has passed, so listo should be high.
    task automatic pulse_fin();
        @(negedge clk);
        fin = 1'b1;
        @(negedge clk);
        fin = 1'b0;
    endtask

    task automatic commit_and_check(input string name, input logic [31:0] er, input bit eo);
        pulse_fin();
        check({name, " resultado"}, resultado, er);
        check({name, " desborde"}, 32'(desborde), 32'(eo));
        check({name, " listo high"}, 32'(listo), 32'd1);
        @(negedge clk);
        check({name, " listo low"}, 32'(listo), 32'd0);
    endtask

    initial begin
        tv[0] = '{"9814",        1'b0, 32'd9814,       1'b0};
        tv[1] = '{"42",          1'b1, 32'd42,         1'b0};
        tv[2] = '{"4294967296",  1'b0, 32'hFFFF_FFFF,  1'b1};
        tv[3] = '{"7",           1'b0, 32'd7,          1'b0};
        tv[4] = '{"4294967295",  1'b1, 32'hFFFF_FFFF,  1'b0};
        tv[5] = '{"99999999999", 1'b0, 32'hFFFF_FFFF,  1'b1};
        tv[6] = '{"",            1'b0, 32'd0,          1'b0};
        tv[7] = '{"0",           1'b1, 32'd0,          1'b0};
        tv[8] = '{"0012",        1'b0, 32'd12,         1'b0};

        reset     = 1'b1;
        dato      = 8'd0;
        num_ready = 1'b0;
        fin       = 1'b0;
        #42;
        check("reset resultado", resultado, 32'd0);
        check("reset listo", 32'(listo), 32'd0);
        check("reset desborde", 32'(desborde), 32'd0);
        check("reset error_dato", 32'(error_dato), 32'd0);
        #8;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < tv[i].digs.len(); k++) begin
                logic [7:0] ch;
                ch = tv[i].digs[k];
                pulse_digit(tv[i].ascii ? ch : ch - 8'h30);
            end
            commit_and_check($sformatf("vec%0d '%s'", i, tv[i].digs), tv[i].exp_res, tv[i].exp_ovf);
        end

        // num_ready held high three cycles appends once
        @(negedge clk);
        dato      = 8'd5;
        num_ready = 1'b1;
        repeat (3) @(negedge clk);
        num_ready = 1'b0;
        commit_and_check("held strobe", 32'd5, 1'b0);

        // invalid digit pulses error_dato and leaves the accumulator alone
        pulse_digit(8'h41);
        check("err pulse high", 32'(error_dato), 32'd1);
        @(negedge clk);
        check("err pulse low", 32'(error_dato), 32'd0);
        commit_and_check("after invalid", 32'd0, 1'b0);

        pulse_digit(8'd3);
        check("valid no err", 32'(error_dato), 32'd0);
        pulse_digit(8'h3A);
        check("0x3A err", 32'(error_dato), 32'd1);
        pulse_digit(8'h0A);
        check("0x0A err", 32'(error_dato), 32'd1);
        pulse_digit(8'h31);
        commit_and_check("invalid mid-number", 32'd31, 1'b0);

        // digit and fin on the same edge: append before commit
        pulse_digit(8'd1);
        pulse_digit(8'd2);
        @(negedge clk);
        dato      = 8'd3;
        num_ready = 1'b1;
        fin       = 1'b1;
        @(negedge clk);
        num_ready = 1'b0;
        fin       = 1'b0;
        check("same edge resultado", resultado, 32'd123);
        check("same edge listo", 32'(listo), 32'd1);

        // fin held high commits exactly once
        pulse_digit(8'd8);
        @(negedge clk);
        fin = 1'b1;
        @(negedge clk);
        check("held fin listo", 32'(listo), 32'd1);
        @(negedge clk);
        check("held fin single pulse", 32'(listo), 32'd0);
        check("held fin resultado", resultado, 32'd8);
        fin = 1'b0;

        // reset mid-number discards the partial value
        pulse_digit(8'd6);
        pulse_digit(8'd6);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset resultado", resultado, 32'd0);
        check("mid reset listo", 32'(listo), 32'd0);
        check("mid reset desborde", 32'(desborde), 32'd0);
        reset = 1'b0;
        commit_and_check("after reset", 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_concatenador_numeros
